// File: rtl/f_memory_pingpong_if.sv
// Bus between the coefficient loader / MAC array and the ping-pong coefficient store.
// data_out carries SIZE lanes of WIDTH bits, each lane a two's complement coefficient.
interface f_memory_pingpong_if #(
   parameter int WIDTH = 16,
   parameter int SIZE  = 64
);
   logic [WIDTH-1:0]           s_data;
   logic                       s_valid;
   logic                       s_ready;
   logic                       swap;
   logic                       swap_err;
   logic                       shadow_full;
   logic [SIZE-1:0][WIDTH-1:0] data_out;
   logic                       out_valid;

   // Loader / consumer side
   modport master (
      output s_data, s_valid, swap,
      input  s_ready, swap_err, shadow_full, data_out, out_valid
   );

   // Coefficient store side
   modport slave (
      input  s_data, s_valid, swap,
      output s_ready, swap_err, shadow_full, data_out, out_valid
   );
endinterface

// File: rtl/f_memory_pingpong.sv
// Double-buffered filter-coefficient store. The loader streams a full filter into
// the shadow bank; an accepted swap copies that bank into the registered parallel
// output and flips bank roles, so the next filter can load without stalling.
module f_memory_pingpong #(
   parameter int WIDTH   = 16,
   parameter int SIZE    = 64,
   parameter int LOGSIZE = 6
) (
   input  logic               clk,
   input  logic               reset,
   f_memory_pingpong_if.slave bus
);

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [LOGSIZE-1:0]         wp_q, wp_d;
   logic                       active_q, active_d;
   logic                       out_valid_q, out_valid_d;
   logic                       swap_err_q, swap_err_d;
   logic [SIZE-1:0][WIDTH-1:0] data_out_q;

   // Both banks; contents survive reset, only the write pointer restarts.
   logic [WIDTH-1:0]           bank_q [2][SIZE];

   logic                       write_beat;
   logic                       last_beat;
   logic                       swap_accept;
   logic                       shadow_sel;

   // Next-state decode for the load/full handshake, swap handling and pointers
   always_comb begin
      shadow_sel  = ~active_q;
      write_beat  = bus.s_valid && (state_q == LOAD);
      last_beat   = write_beat && (wp_q == LOGSIZE'(SIZE - 1));
      swap_accept = bus.swap && (state_q == FULL);

      state_d     = state_q;
      wp_d        = wp_q;
      active_d    = active_q;
      out_valid_d = out_valid_q;
      // A swap in LOAD is always rejected, even on the beat that fills the bank.
      swap_err_d  = bus.swap && (state_q == LOAD);

      if (write_beat) begin
         wp_d = wp_q + LOGSIZE'(1);   // wraps to 0 after the last beat
      end
      if (last_beat) begin
         state_d = FULL;
      end
      if (swap_accept) begin
         state_d     = LOAD;
         active_d    = ~active_q;
         out_valid_d = 1'b1;
      end
   end

   // Control registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LOAD;
         wp_q        <= '0;
         active_q    <= 1'b0;
         out_valid_q <= 1'b0;
         swap_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         active_q    <= active_d;
         out_valid_q <= out_valid_d;
         swap_err_q  <= swap_err_d;
      end
   end

   // Streaming writes land only in the shadow bank; the active bank is never written
   always_ff @(posedge clk) begin
      if (write_beat) begin
         bank_q[shadow_sel][wp_q] <= bus.s_data;
      end
   end

   // One output lane per coefficient, reloaded from the shadow bank on an accepted swap
   generate
      for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
         always_ff @(posedge clk) begin
            if (reset) begin
               data_out_q[gi] <= '0;
            end else if (swap_accept) begin
               data_out_q[gi] <= bank_q[shadow_sel][gi];
            end
         end
      end
   endgenerate

   assign bus.s_ready     = (state_q == LOAD);
   assign bus.shadow_full = (state_q == FULL);
   assign bus.swap_err    = swap_err_q;
   assign bus.data_out    = data_out_q;
   assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_f_memory_pingpong.sv
// Bench for f_memory_pingpong: directed scenarios followed by random traffic.
// The driver updates a word-count based reference model on every edge and queues
// the expected outputs; a negedge monitor pops and compares against the DUT.
module tb_f_memory_pingpong;
   localparam int WIDTH   = 16;
   localparam int SIZE    = 64;
   localparam int LOGSIZE = 6;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   f_memory_pingpong_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

   f_memory_pingpong #(.WIDTH(WIDTH), .SIZE(SIZE), .LOGSIZE(LOGSIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   typedef struct {
      logic                       s_ready;
      logic                       full;
      logic                       err;
      logic                       ov;
      logic [SIZE-1:0][WIDTH-1:0] data;
      int                         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // Reference model: count of words in the shadow bank, bank images, output image
   logic [WIDTH-1:0]           m_bank [2][SIZE];
   bit                         m_act;
   int                         m_count;
   logic [SIZE-1:0][WIDTH-1:0] m_out;
   bit                         m_ov;
   bit                         m_err;

   task automatic model_edge(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit sw);
      if (r) begin
         m_act   = 1'b0;
         m_count = 0;
         m_out   = '0;
         m_ov    = 1'b0;
         m_err   = 1'b0;
      end else begin
         bit full_now;
         full_now = (m_count == SIZE);
         m_err    = sw && !full_now;
         if (sw && full_now) begin
            for (int k = 0; k < SIZE; k++) m_out[k] = m_bank[!m_act][k];
            m_act   = !m_act;
            m_count = 0;
            m_ov    = 1'b1;
         end else if (v && !full_now) begin
            m_bank[!m_act][m_count] = d;
            m_count++;
         end
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] d, input bit sw);
      exp_t e;
      reset       = r;
      bus.s_valid = v;
      bus.s_data  = d;
      bus.swap    = sw;
      @(posedge clk);
      cyc++;
      model_edge(r, v, d, sw);
      e.s_ready = (m_count < SIZE);
      e.full    = (m_count == SIZE);
      e.err     = m_err;
      e.ov      = m_ov;
      e.data    = m_out;
      e.cyc     = cyc;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic load_words(input int n, input int mode, input bit sw_last);
      // mode 0: k+1, mode 1: -k, mode 2: random
      for (int k = 0; k < n; k++) begin
         logic [WIDTH-1:0] w;
         if (mode == 0)      w = WIDTH'(k + 1);
         else if (mode == 1) w = WIDTH'(-k);
         else                w = WIDTH'($urandom);
         step(1'b0, 1'b1, w, sw_last && (k == n - 1));
      end
   endtask

   task automatic chk_bit(input string name, input int c, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %b want %b", name, c, act, exp);
      end
   endtask

   // Monitor: compare every presented output against the queued expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk_bit("s_ready", e.cyc, bus.s_ready, e.s_ready);
         chk_bit("shadow_full", e.cyc, bus.shadow_full, e.full);
         chk_bit("swap_err", e.cyc, bus.swap_err, e.err);
         chk_bit("out_valid", e.cyc, bus.out_valid, e.ov);
         checks++;
         if (bus.data_out !== e.data) begin
            int idx;
            idx = 0;
            for (int k = SIZE - 1; k >= 0; k--) begin
               if (bus.data_out[k] !== e.data[k]) idx = k;
            end
            errors++;
            $display("FAIL data_out cycle %0d lane %0d got %h want %h",
                     e.cyc, idx, bus.data_out[idx], e.data[idx]);
         end
      end
   end

   initial begin
      reset       = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.swap    = 1'b0;
      m_act       = 1'b0;
      m_count     = 0;
      m_out       = '0;
      m_ov        = 1'b0;
      m_err       = 1'b0;

      // 1: reset held two cycles
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0);

      // 2: stream k+1, then swap
      load_words(SIZE, 0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);

      // 3: 10 words, early swap rejected, finish load, hold s_valid while full
      load_words(10, 1, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      for (int k = 10; k < SIZE; k++) step(1'b0, 1'b1, WIDTH'(-k), 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 16'h7777, 1'b0);

      // 4: swap in the -k filter, then a third load refills bank0
      step(1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (bus.data_out[63] !== 16'hFFC1 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL lane63_after_swap got %h/%b want ffc1/1", bus.data_out[63], bus.out_valid);
      end
      load_words(SIZE, 2, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);

      // 5: reset mid-load, then 63 beats + rejected swap, 64th beat, accepted swap
      load_words(30, 2, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0);
      load_words(SIZE - 1, 0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);

      // 6: swap on the 64th beat is rejected, the next-cycle swap is accepted
      load_words(SIZE, 1, 1'b1);
      step(1'b0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         bit r, v, sw;
         r  = ($urandom_range(0, 999) < 3);
         v  = ($urandom_range(0, 99) < 80);
         sw = ($urandom_range(0, 99) < 5);
         step(r, v, WIDTH'($urandom), sw);
      end

      bus.s_valid = 1'b0;
      bus.swap    = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
